// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 VGA scan generator with pixel-tick divider.
// Produces col/row for the renderer, samples its 12-bit colour on the last
// clk of each pixel period and drives registered sync/RGB to the DAC.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input that
// replaces visible colour with eight 80-column colour bars.
module vga_scan #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [9:0]  col,
    output logic [9:0]  row,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        pix_tick,
    output logic        frame_start
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned RGB_W    = 12;
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = H_VIS + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = V_VIS + V_FP + V_SYNC;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             tick_nxt;
    logic [CNT_W-1:0] col_nxt;
    logic [CNT_W-1:0] row_nxt;
    logic             frame_wrap;
    logic             visible;
    logic             hs_nxt;
    logic             vs_nxt;
    logic [RGB_W-1:0] pix_src;
    logic [RGB_W-1:0] rgb_nxt;

    // Divider: tick flop is loaded one clk early so it is high exactly while div_cnt is at its last value
    always_comb begin
        div_nxt  = div_cnt + DIV_W'(1);
        tick_nxt = 1'b0;
        if (div_cnt == DIV_LAST) begin
            div_nxt = '0;
        end
        if (div_nxt == DIV_LAST) begin
            tick_nxt = 1'b1;
        end
    end

    // Scan counters: col advances per tick, row advances and both wrap together
    always_comb begin
        col_nxt    = col;
        row_nxt    = row;
        frame_wrap = 1'b0;
        if (pix_tick) begin
            if (col == COL_LAST) begin
                col_nxt = '0;
                if (row == ROW_LAST) begin
                    row_nxt    = '0;
                    frame_wrap = 1'b1;
                end else begin
                    row_nxt = row + CNT_W'(1);
                end
            end else begin
                col_nxt = col + CNT_W'(1);
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]       bar_idx;
    logic [RGB_W-1:0] bar_rgb;

    // Colour bars: bar index bits map straight onto the r/g/b nibbles
    always_comb begin
        bar_idx = 3'(col / CNT_W'(80));
        bar_rgb = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
        pix_src = test_mode ? bar_rgb : rgb_in;
    end
`else
    // Renderer colour passes straight through
    always_comb begin
        pix_src = rgb_in;
    end
`endif

    // Sync/blank decode on the currently presented col/row; blank muxes to a constant so X never leaks
    always_comb begin
        visible = (col < CNT_W'(H_VIS)) && (row < CNT_W'(V_VIS));
        hs_nxt  = !((col >= CNT_W'(HS_START)) && (col < CNT_W'(HS_END)));
        vs_nxt  = !((row >= CNT_W'(VS_START)) && (row < CNT_W'(VS_END)));
        rgb_nxt = '0;
        if (visible) begin
            rgb_nxt = pix_src;
        end
    end

    // State and output registers; pixel outputs update only on the tick
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            pix_tick    <= 1'b0;
            col         <= '0;
            row         <= '0;
            frame_start <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            div_cnt     <= div_nxt;
            pix_tick    <= tick_nxt;
            col         <= col_nxt;
            row         <= row_nxt;
            frame_start <= frame_wrap;
            if (pix_tick) begin
                hs    <= hs_nxt;
                vs    <= vs_nxt;
                vga_r <= rgb_nxt[11:8];
                vga_g <= rgb_nxt[7:4];
                vga_b <= rgb_nxt[3:0];
            end
        end
    end

endmodule

// File: doc/vga_scan.md
Name: vga_scan

Overview:
- Display-side end of the pixel interface that the renderer feeds. The renderer consumes `col`/`row` and returns a registered 12-bit `rgb`; this block produces those coordinates and consumes that colour.
- Generates 640x480@60 VGA timing from the system clock using an internal pixel-tick divider.
- Drives `col`/`row` to the renderer and samples the returned 12-bit colour.
- Emits pixel-aligned `hs`/`vs` and 4:4:4 RGB to the DAC pins, with blanking forced to black.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal values 2..16.
- H_VIS, 640, visible columns.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).

Ports:
- clk  input  1  system clock, same clock as the renderer.
- rst  input  1  synchronous, active-high reset.
- rgb_in  input  12  colour from the renderer, {r[11:8], g[7:4], b[3:0]}.
- col  output  10  current horizontal count, 0..H_TOTAL-1.
- row  output  10  current vertical count, 0..V_TOTAL-1.
- hs  output  1  horizontal sync, active low.
- vs  output  1  vertical sync, active low.
- vga_r  output  4  red to DAC.
- vga_g  output  4  green to DAC.
- vga_b  output  4  blue to DAC.
- pix_tick  output  1  one-clk pulse marking each pixel boundary.
- frame_start  output  1  one-clk pulse at col=0, row=0.

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Derived constants: H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525.
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps to 0.
  - `pix_tick` = 1 on the clk cycle where div_cnt == CLK_DIV-1.
- Scan counters (advance only on `pix_tick`):
  - `col` increments; at H_TOTAL-1 it wraps to 0 and `row` increments.
  - `row` wraps from V_TOTAL-1 to 0 on the same tick that `col` wraps.
  - `col`/`row` are registered and stable for a full pixel period (CLK_DIV clks).
- Renderer latency budget: the renderer has CLK_DIV-1 clks from a `col`/`row` change to a valid `rgb_in`.
- Sampling: `rgb_in` is captured on the pix_tick cycle, i.e. the last clk of that pixel period.
- Output pipeline:
  - `hs`, `vs`, vga_r/g/b are all registered and update together on pix_tick.
  - They therefore describe the pixel whose `col`/`row` was presented one pixel period earlier. Latency is exactly one pixel period (CLK_DIV clks), identical for sync, colour and blank.
- Sync and blanking, evaluated on the sampled `col`/`row`:
  - hs = 0 iff H_VIS+H_FP <= col < H_VIS+H_FP+H_SYNC (656..751).
  - vs = 0 iff V_VIS+V_FP <= row < V_VIS+V_FP+V_SYNC (490..491).
  - Visible iff col < H_VIS and row < V_VIS.
  - Visible: vga_rgb = rgb_in. Not visible: vga_rgb = 0.
- frame_start: one-clk pulse on the clk cycle after the counters wrap to (0,0), coincident with the first clk of that pixel period.
- Reset:
  - `div_cnt`, `col`, `row` = 0.
  - hs = vs = 1; vga_r/g/b = 0; pix_tick = 0; frame_start = 0.
  - First pix_tick occurs CLK_DIV clks after `rst` deasserts.
  - No frame_start pulse is issued for the reset-entered (0,0).
- Reset mid-line or mid-frame: all state returns to reset values on the next clk. No partial sync pulse is extended.
- `rgb_in` is ignored during blanking. X on `rgb_in` during blanking must not propagate to the outputs.
- `col`/`row` never exceed H_TOTAL-1 / V_TOTAL-1. The renderer's `row > 600` test can never fire from scan position alone.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Extra input port `test_mode` (1 bit).
  - When test_mode = 1, the visible colour is replaced by 8 vertical bars of 80 columns each, indexed bar = col[9:0]/80 using the sampled col.
  - Bar colour = {4{bar[2]}, 4{bar[1]}, 4{bar[0]}}, i.e. black, blue, green, cyan, red, magenta, yellow, white.
  - Timing, latency and blanking are unchanged.
- Undefined: the port is absent and the output is always rgb_in gated by blank.

Test Plan:
- Reset, then release -> hs=1, vs=1, rgb=0, col=row=0 held for 4 clks; first pix_tick at clk 4; col=1 at clk 5.
- Free-run one line -> hs low for exactly 96 pix_ticks (384 clks), first low tick being the one following col=656; line period 3200 clks.
- Free-run 2 frames -> vs low for 2 lines (6400 clks); frame_start pulses 1,680,000 clks apart; row wraps 524->0 on the same tick that col wraps 799->0.
- rgb_in = 12'hF0A constant -> vga = F,0,A for col 0..639 / row 0..479 (one pixel delayed); 0 at col 640..799 and rows 480..524; rgb_in = X during blanking -> outputs stay 0.
- Assert rst for 1 clk at col=700, row=100 (inside hs low) -> next clk hs=1, col=row=0, vga=0; timing restarts as after the first reset.
- VGA_TEST_PATTERN_EN defined, test_mode=1 -> col 160..239 output 12'h0F0, col 560..639 output 12'hFFF; test_mode=0 -> rgb_in passes through.
